// File: rtl/div_radix2_core_pkg.sv
// Shared constants and helpers for the radix-2 restoring divider.
// Optional CLZ-based iteration skipping is enabled with DIV_CLZ_SKIP_EN.
package div_radix2_core_pkg;

  localparam int DIV_WIDTH_DEF = 32;

  function automatic int clz_bits(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/div_radix2_core_if.sv
// Request/response bundle between a divider client and div_radix2_core.
// Field names match the core's port list one-to-one.
interface div_radix2_core_if
  import div_radix2_core_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
);

  localparam int LW = clz_bits(DIV_WIDTH);

  logic                 start;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic [LW-1:0]        dividend_CLZ;
  logic [LW-1:0]        divisor_CLZ;
  logic                 divisor_is_zero;
  logic                 done;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;

  modport master (
    output start,
    output dividend,
    output divisor,
    output dividend_CLZ,
    output divisor_CLZ,
    output divisor_is_zero,
    input  done,
    input  quotient,
    input  remainder
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    input  dividend_CLZ,
    input  divisor_CLZ,
    input  divisor_is_zero,
    output done,
    output quotient,
    output remainder
  );

endinterface

// File: rtl/div_radix2_step.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder, trial-subtract the divisor, keep the result if no borrow.
module div_radix2_step #(
  parameter int DIV_WIDTH = 32
) (
  input  logic [DIV_WIDTH-1:0] rem_i,
  input  logic                 bit_i,
  input  logic [DIV_WIDTH-1:0] dvs_i,
  output logic [DIV_WIDTH-1:0] rem_o,
  output logic                 q_o
);

  logic [DIV_WIDTH:0]   trial;
  logic [DIV_WIDTH+1:0] diff;
  logic                 unused_msb;

  assign trial = {rem_i, bit_i};
  assign diff  = {1'b0, trial} - {2'b00, dvs_i};
  assign q_o   = ~diff[DIV_WIDTH+1];
  assign rem_o = q_o ? diff[DIV_WIDTH-1:0]
                     : trial[DIV_WIDTH-1:0];

  // The kept remainder is always below the divisor, so bit W is zero
  assign unused_msb = diff[DIV_WIDTH] ^ trial[DIV_WIDTH];

endmodule

// File: rtl/div_radix2_core.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// DIV_CLZ_SKIP_EN: use CLZ hints to skip leading steps and early-out.
module div_radix2_core
  import div_radix2_core_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input logic              clk,
  input logic              rst,
  div_radix2_core_if.slave bus
);

  localparam int W  = DIV_WIDTH;
  localparam int LW = clz_bits(DIV_WIDTH);
  localparam int CW = LW + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   res_q, res_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;

  logic           accept;
  logic           early;
  logic [W-1:0]   early_quo;
  logic [CW-1:0]  init_cnt;
  logic [LW-1:0]  shamt;
  logic [2*W-1:0] ini_cat;

  logic [W-1:0]   rem_in;
  logic [W-1:0]   acc_in;
  logic [W-1:0]   dvs_in;
  logic [W-1:0]   step_rem;
  logic           step_q;
  logic [W-1:0]   acc_next;

  assign accept = bus.start
                & ((state_q == IDLE) | (cnt_q == '0));

`ifdef DIV_CLZ_SKIP_EN
  logic [LW-1:0] span;

  assign span      = bus.divisor_CLZ - bus.dividend_CLZ;
  assign early     = bus.divisor_is_zero
                   | (bus.dividend_CLZ > bus.divisor_CLZ);
  assign early_quo = bus.divisor_is_zero ? '1 : '0;
  assign init_cnt  = early ? '0 : CW'(span);
  // Dividend bits above the first N are known to give zero quotient bits
  assign shamt     = early ? '0 : LW'(W - 1) - span;
`else
  assign early     = 1'b0;
  assign early_quo = '0;
  assign init_cnt  = CW'(W - 1);
  assign shamt     = '0;
`endif

  assign ini_cat = {{W{1'b0}}, bus.dividend} << shamt;

  // The accepting edge already performs the first step
  assign rem_in = accept ? ini_cat[2*W-1:W] : rem_q;
  assign acc_in = accept ? ini_cat[W-1:0]   : acc_q;
  assign dvs_in = accept ? bus.divisor      : dvs_q;

  div_radix2_step #(
    .DIV_WIDTH (W)
  ) u_step (
    .rem_i (rem_in),
    .bit_i (acc_in[W-1]),
    .dvs_i (dvs_in),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  assign acc_next = {acc_in[W-2:0], step_q};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    res_d   = res_q;
    done_d  = 1'b0;
    if (accept) begin
      state_d = RUN;
      dvs_d   = bus.divisor;
      rem_d   = step_rem;
      acc_d   = acc_next;
      cnt_d   = init_cnt;
      if (early) begin
        done_d = 1'b1;
        quo_d  = early_quo;
        res_d  = bus.dividend;
      end else if (init_cnt == '0) begin
        done_d = 1'b1;
        quo_d  = acc_next;
        res_d  = step_rem;
      end
    end else if (state_q == RUN) begin
      if (cnt_q != '0) begin
        rem_d = step_rem;
        acc_d = acc_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          done_d = 1'b1;
          quo_d  = acc_next;
          res_d  = step_rem;
        end
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = res_q;

endmodule

// File: tb/tb_div_radix2_core.sv
// Randomised and directed bench for div_radix2_core against a plain
// arithmetic model (a/b, a%b, latency from CLZ rules).
module tb_div_radix2_core;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_radix2_core_if #(.DIV_WIDTH(32)) bus ();

  div_radix2_core #(.DIV_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [4:0] clz32(input logic [31:0] v);
    for (int i = 31; i >= 0; i--)
      if (v[i]) return 5'(31 - i);
    return 5'd31;
  endfunction

  task automatic scramble();
    bus.dividend        = $urandom;
    bus.divisor         = $urandom;
    bus.dividend_CLZ    = 5'($urandom);
    bus.divisor_CLZ     = 5'($urandom);
    bus.divisor_is_zero = 1'($urandom);
  endtask

  task automatic op(input logic [31:0] a,
                    input logic [31:0] b,
                    input logic [4:0]  ac,
                    input logic [4:0]  bc,
                    input logic        dz,
                    input string       tag,
                    input bit          chain);
    int          exp_n;
    int          lat;
    bit          held;
    logic [31:0] eq;
    logic [31:0] er;
`ifdef DIV_CLZ_SKIP_EN
    if (dz || ac > bc) exp_n = 1;
    else exp_n = int'(bc) - int'(ac) + 1;
`else
    exp_n = 32;
`endif
    eq = (b == 0) ? 32'hFFFF_FFFF : a / b;
    er = (b == 0) ? a : a % b;
    if (!chain) begin
      @(negedge clk);
      check($sformatf("%s_idle", tag), 64'(bus.done), 64'd0);
    end
    bus.start           = 1'b1;
    bus.dividend        = a;
    bus.divisor         = b;
    bus.dividend_CLZ    = ac;
    bus.divisor_CLZ     = bc;
    bus.divisor_is_zero = dz;
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
    lat  = 1;
    held = 1'b1;
    while (!bus.done && lat < 40) begin
      if (bus.quotient !== prev_q || bus.remainder !== prev_r)
        held = 1'b0;
      @(negedge clk);
      lat++;
      scramble();
    end
    check($sformatf("%s_lat", tag), 64'(lat), 64'(exp_n));
    check($sformatf("%s_q", tag), 64'(bus.quotient), 64'(eq));
    check($sformatf("%s_r", tag), 64'(bus.remainder), 64'(er));
    check($sformatf("%s_hold", tag), 64'(held), 64'd1);
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic rand_op(input int i, input bit chain);
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 9) == 0) b = '0;
    else b = $urandom >> $urandom_range(0, 31);
    op(a, b, clz32(a), clz32(b), b == 0,
       $sformatf("rnd%0d", i), chain);
  endtask

  initial begin
    int seen;
    rst                 = 1'b1;
    bus.start           = 1'b0;
    bus.dividend        = '0;
    bus.divisor         = '0;
    bus.dividend_CLZ    = '0;
    bus.divisor_CLZ     = '0;
    bus.divisor_is_zero = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_q", 64'(bus.quotient), 64'd0);
    check("rst_r", 64'(bus.remainder), 64'd0);
    rst = 1'b0;

    op(32'd100, 32'd7, 5'd25, 5'd29, 1'b0, "d100_7", 1'b0);
    op(32'd5, 32'd0, 5'd0, 5'd31, 1'b1, "d5_0", 1'b0);
    op(32'hFFFF_FFFF, 32'd1, 5'd0, 5'd31, 1'b0, "dmax_1", 1'b0);
    op(32'd3, 32'd10, 5'd30, 5'd28, 1'b0, "d3_10", 1'b0);

    op(32'd100, 32'd7, 5'd25, 5'd29, 1'b0, "b2b_a", 1'b0);
    op(32'd1000, 32'd3, clz32(32'd1000), clz32(32'd3),
       1'b0, "b2b_b", 1'b1);

    // Reset mid-division, then reset coincident with a start
    @(negedge clk);
    bus.start           = 1'b1;
    bus.dividend        = 32'hFFFF_FFFF;
    bus.divisor         = 32'd1;
    bus.dividend_CLZ    = 5'd0;
    bus.divisor_CLZ     = 5'd31;
    bus.divisor_is_zero = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.dividend = 32'd9;
    bus.divisor  = 32'd2;
    bus.dividend_CLZ = clz32(32'd9);
    bus.divisor_CLZ  = clz32(32'd2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("rst_abort_done", 64'(seen), 64'd0);
    check("rst_abort_q", 64'(bus.quotient), 64'd0);
    check("rst_abort_r", 64'(bus.remainder), 64'd0);
    prev_q = '0;
    prev_r = '0;
    op(32'd9, 32'd2, clz32(32'd9), clz32(32'd2),
       1'b0, "post_rst", 1'b0);

    for (int i = 0; i < 40; i++)
      rand_op(i, $urandom_range(0, 2) == 0);

    @(negedge clk);
    check("final_idle", 64'(bus.done), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
